// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and counter sizing for reset_sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, WAIT_READY} rst_seq_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged active-low per-domain reset release with ready handshake and timeout
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_DOMAINS      = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int ACK_TIMEOUT    = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sw_rst_req,
    input  logic [N_DOMAINS-1:0] i_domain_ready,
    output logic [N_DOMAINS-1:0] o_rst_n,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, ACK_TIMEOUT);
    localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    rst_seq_state_t       state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [N_DOMAINS-1:0] rst_n_nx;
    logic                 busy_nx, done_nx, err_nx;

    // state, shared counter, domain index and all outputs are registered here
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ASSERT;
            cnt     <= '0;
            idx     <= '0;
            o_rst_n <= '0;
            o_busy  <= 1'b1;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            o_rst_n <= rst_n_nx;
            o_busy  <= busy_nx;
            o_done  <= done_nx;
            o_err   <= err_nx;
        end
    end

    // next state; a software request restarts from any state and wins over ready/timeout
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CW'(1);
        idx_nx   = idx;
        rst_n_nx = o_rst_n;
        done_nx  = 1'b0;
        err_nx   = o_err;
        if (i_sw_rst_req) begin
            state_nx = ASSERT;
            cnt_nx   = '0;
            idx_nx   = '0;
            rst_n_nx = '0;
            err_nx   = 1'b0;
        end else begin
            case (state)
                ASSERT: begin
                    if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        rst_n_nx[0] = 1'b1;
                        cnt_nx      = '0;
                        if (N_DOMAINS == 1) begin
                            state_nx = WAIT_READY;
                        end else begin
                            state_nx = RELEASE;
                            idx_nx   = IW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (cnt == CW'(STAGGER_CYCLES - 1)) begin
                        rst_n_nx[idx] = 1'b1;
                        cnt_nx        = '0;
                        if (idx == IW'(N_DOMAINS - 1))
                            state_nx = WAIT_READY;
                        else
                            idx_nx = idx + IW'(1);
                    end
                end
                WAIT_READY: begin
                    if (&i_domain_ready) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                default: cnt_nx = '0;
            endcase
        end
        busy_nx = (state_nx != IDLE);
    end

endmodule
